// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative RV32M divider.
// Op codes, FSM states and the execute-stage result-select width.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int EX_SEL_W = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  function automatic logic op_signed(logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_rem(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between execute stage and divider.
// master drives the request side, slave is the divider.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output busy, done, result
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Shift in a dividend bit, trial-subtract, keep on no borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            bit_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {2'b00, divisor};
  assign q_bit   = ~diff[XLEN+1];
  assign rem_out = q_bit ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one bit per cycle.
// Special cases finish at acceptance; flush aborts without done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nx;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd, dsr, quo, res;
  logic [XLEN:0]   rem;
  logic            q_neg, r_neg, want_rem;

  logic            accept, sgn, zero_div, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, q_fix, r_fix;
  logic [XLEN:0]   step_rem;
  logic            step_q;

  assign accept = bus.start && !bus.flush &&
                  (state == DIV_IDLE || state == DIV_DONE);
  assign sgn      = op_signed(bus.op);
  assign zero_div = (bus.divisor == '0);
  assign ovf      = sgn && (bus.dividend == MIN_NEG) &&
                    (bus.divisor == '1);
  assign special  = zero_div || ovf;

  // Negating MIN_NEG yields itself, which is the right unsigned magnitude.
  assign a_mag = (sgn && bus.dividend[XLEN-1]) ? -bus.dividend
                                               : bus.dividend;
  assign b_mag = (sgn && bus.divisor[XLEN-1]) ? -bus.divisor
                                              : bus.divisor;

  always_comb begin
    spec_res = '0;
    if (zero_div)
      spec_res = op_rem(bus.op) ? bus.dividend : '1;
    else
      spec_res = op_rem(bus.op) ? '0 : MIN_NEG;
  end

  assign q_fix = q_neg ? -quo : quo;
  assign r_fix = r_neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .bit_in  (dvd[XLEN-1]),
    .divisor (dsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      DIV_IDLE, DIV_DONE:
        state_nx = accept ? (special ? DIV_DONE : DIV_CALC)
                          : DIV_IDLE;
      DIV_CALC:
        if (cnt == '0) state_nx = DIV_FIX;
      DIV_FIX:
        state_nx = DIV_DONE;
      default:
        state_nx = DIV_IDLE;
    endcase
    if (bus.flush) state_nx = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      quo      <= '0;
      rem      <= '0;
      res      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      want_rem <= 1'b0;
    end else if (!bus.flush) begin
      if (accept) begin
        if (special) begin
          res <= spec_res;
        end else begin
          dvd      <= a_mag;
          dsr      <= b_mag;
          rem      <= '0;
          quo      <= '0;
          cnt      <= CW'(XLEN-1);
          q_neg    <= sgn && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
          r_neg    <= sgn && bus.dividend[XLEN-1];
          want_rem <= op_rem(bus.op);
        end
      end else if (state == DIV_CALC) begin
        rem <= step_rem;
        quo <= {quo[XLEN-2:0], step_q};
        dvd <= {dvd[XLEN-2:0], 1'b0};
        cnt <= cnt - 1'b1;
      end else if (state == DIV_FIX) begin
        res <= want_rem ? r_fix : q_fix;
      end
    end
  end

  assign bus.busy   = (state == DIV_CALC) || (state == DIV_FIX);
  assign bus.done   = (state == DIV_DONE);
  assign bus.result = res;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider for the M-extension DIV, DIVU, REM and REMU instructions. It sits in the execute stage beside the ALU and multiplier. Its registered result is one input of the execute-stage result-select mux. The hazard unit stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, 32: operand and result width; must be a power of two ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a division; accepted only in IDLE or DONE.
- `op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend`  in  XLEN  rs1 value; sampled only on acceptance.
- `divisor`  in  XLEN  rs2 value; sampled only on acceptance.
- `flush`  in  1  synchronous abort from branch mispredict or trap.
- `busy`  out  1  high while a division is in progress (CALC, FIX).
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  quotient or remainder; holds its value until the next acceptance.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Acceptance:** `start` high in IDLE or DONE with `flush` low.
  - `start` in CALC or FIX is ignored.
- **Special cases** (resolved at acceptance; next state DONE):
  - Divisor 0: quotient is all ones; remainder is the dividend.
  - Signed overflow (dividend = 2^(XLEN-1), divisor = all ones, op DIV/REM): quotient is 2^(XLEN-1); remainder is 0.
- **Normal case** at acceptance:
  - Latch magnitudes (|x| for signed ops, raw value for unsigned ops).
  - Latch quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
  - Clear the XLEN+1-bit partial remainder; counter = XLEN-1; next state CALC.
- **CALC:** one restoring step per cycle, MSB first.
  - Shift the remainder left, bringing in the next dividend bit, then trial-subtract the divisor.
  - Quotient bit = 1 if the trial result is non-negative, and that result is kept.
  - Leave to FIX when the counter reaches 0.
- **FIX:** apply two's-complement negation per the latched signs; select quotient (DIV/DIVU) or remainder (REM/REMU); register `result`; next state DONE.
- **DONE:** `done` is high; next state IDLE unless a new start is accepted.
- **Arithmetic:**
  - The trial subtract is XLEN+1 bits wide, with the borrow taken as the sign.
  - Magnitude of 2^(XLEN-1) is represented correctly as unsigned.
  - All outputs are truncated to XLEN bits.
- **Flush:** highest priority in every state. Next state is IDLE, no `done` pulse, `result` unchanged. Flush and start in the same cycle means start is dropped.

## Timing
- Reset (async assert, sync release): state IDLE, `busy` 0, `done` 0, `result` 0, counter 0, internal registers 0.
- Reset asserted mid-operation behaves as above; no `done` is produced.
- **Normal latency:** start accepted at edge E0.
  - `busy` is high from E0 to E(XLEN+1).
  - `done` is high for the single cycle after E(XLEN+1): XLEN+2 cycles start-to-done, 34 for XLEN=32.
- **Special-case latency:** `done` is high in the cycle after E0; `busy` stays low.
- **Back-to-back:** `start` during the DONE cycle is accepted. `done` drops and `busy` rises at the same edge.
- `busy` and `done` are never high together.

## Structure
- A shared package or header holds:
  - op encodings `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`;
  - state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_FIX`, `DIV_DONE`.
- The execute-stage result-select width constant is shared through the same package.
- One sub-module, `div_step`: a combinational restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
- The FSM, counter, sign handling and result register stay in `div_unit`.

## Test plan
- DIV 100 / 7: `done` exactly 34 cycles after start; `result` = 14. Repeat as REM: `result` = 2.
- DIV −20 / 6: `result` = −3 (0xFFFFFFFD). REM −20 / 6: `result` = −2 (0xFFFFFFFE).
- DIVU 0xFFFFFFFF / 2: `result` = 0x7FFFFFFF. REMU 0xFFFFFFFF / 2: `result` = 1.
- Divisor 0:
  - DIV 5/0: `result` = 0xFFFFFFFF.
  - REM 5/0: `result` = 5.
  - `done` arrives one cycle after start; `busy` never rises.
- DIV 0x80000000 / 0xFFFFFFFF: `result` = 0x80000000. REM with the same operands: `result` = 0. Both at 1-cycle latency.
- Start DIV 100/7, then:
  - assert `flush` at cycle 10: `busy` drops next cycle, no `done`, `result` holds its prior value;
  - on a separate run, pulse `rst_n` low at cycle 20: all outputs 0 immediately;
  - a fresh start after either abort completes correctly.
